// File: rtl/struct_pkg.sv
// Shared types and stall-depth constants for the pipeline hazard controller.
package struct_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  localparam int unsigned LOAD_USE_STALLS  = 1;
  localparam int unsigned NOFWD_EX_STALLS  = 2;
  localparam int unsigned NOFWD_MEM_STALLS = 1;
  localparam int unsigned LEFT_W           = 2;

endpackage

// File: rtl/hazard_ctrl_src_check.sv
// Per-source dependence check: producer match flags, required stall depth
// and the forward select this source would use if no stall starts.
module hz_src_check
  import struct_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             fwd_on,
  input  logic             src_use,
  input  logic [REG_W-1:0] src,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  output logic             ex_match_c,
  output logic             mem_match_c,
  output logic [1:0]       need_c,
  output logic [1:0]       fwd_c
);

  logic live;

  always_comb begin
    live        = src_use && (src != '0);
    ex_match_c  = live && ex_valid && ex_reg_write && (ex_rd == src);
    mem_match_c = live && mem_valid && mem_reg_write && (mem_rd == src);
    need_c      = '0;
    fwd_c       = FWD_REG;
    if (fwd_on) begin
      // Only a load in EX cannot be bypassed; everything else forwards.
      if (ex_match_c && ex_mem_read) begin
        need_c = 2'(LOAD_USE_STALLS);
      end
      if (ex_match_c && !ex_mem_read) begin
        fwd_c = FWD_EXMEM;
      end else if (mem_match_c) begin
        fwd_c = FWD_MEMWB;
      end
    end else begin
      if (ex_match_c) begin
        need_c = 2'(NOFWD_EX_STALLS);
      end else if (mem_match_c) begin
        need_c = 2'(NOFWD_MEM_STALLS);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: stall/bubble/flush decisions, forward selects
// and saturating stall/flush event counters.
module hazard_ctrl
  import struct_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             isForw_ON,
  input  logic             id_isValid,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_isValid,
  input  logic             ex_regWrite,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_isValid,
  input  logic             mem_regWrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic [1:0]       forwA,
  output logic [1:0]       forwB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e         state_q, state_d;
  logic [LEFT_W-1:0] left_q, left_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [1:0]        need1, need2, fwd1, fwd2, need_max;
  logic [3:0]        unused_match;

  hz_src_check #(.REG_W(REG_W)) u_chk_rs1 (
    .fwd_on        (isForw_ON),
    .src_use       (id_isValid && id_use_rs1),
    .src           (id_rs1),
    .ex_valid      (ex_isValid),
    .ex_reg_write  (ex_regWrite),
    .ex_mem_read   (ex_memRead),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_isValid),
    .mem_reg_write (mem_regWrite),
    .mem_rd        (mem_rd),
    .ex_match_c    (unused_match[0]),
    .mem_match_c   (unused_match[1]),
    .need_c        (need1),
    .fwd_c         (fwd1)
  );

  hz_src_check #(.REG_W(REG_W)) u_chk_rs2 (
    .fwd_on        (isForw_ON),
    .src_use       (id_isValid && id_use_rs2),
    .src           (id_rs2),
    .ex_valid      (ex_isValid),
    .ex_reg_write  (ex_regWrite),
    .ex_mem_read   (ex_memRead),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_isValid),
    .mem_reg_write (mem_regWrite),
    .mem_rd        (mem_rd),
    .ex_match_c    (unused_match[2]),
    .mem_match_c   (unused_match[3]),
    .need_c        (need2),
    .fwd_c         (fwd2)
  );

  // Next state, control outputs and counter updates.
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    stall       = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    pc_sel      = 1'b0;
    pc_target   = '0;
    forwA       = FWD_REG;
    forwB       = FWD_REG;
    need_max    = (need1 > need2) ? need1 : need2;

    if (ex_redirect) begin
      // The stalled ID instruction is younger than the branch; drop it.
      flush     = 1'b1;
      bubble    = 1'b1;
      pc_sel    = 1'b1;
      pc_target = ex_target;
      state_d   = RUN;
      left_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (need_max != 2'd0) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (need_max > 2'd1) begin
              state_d = STALL;
              left_d  = LEFT_W'(need_max - 2'd1);
            end
          end
        end
        STALL: begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (left_q <= LEFT_W'(1)) begin
            state_d = RUN;
            left_d  = '0;
          end else begin
            left_d = left_q - LEFT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          left_d  = '0;
        end
      endcase
    end

    if (!stall) begin
      forwA = fwd1;
      forwB = fwd2;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      left_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: owed-stall-cycles reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             isForw_ON;
  logic             id_isValid, id_use_rs1, id_use_rs2;
  logic [REG_W-1:0] id_rs1, id_rs2;
  logic             ex_isValid, ex_regWrite, ex_memRead;
  logic [REG_W-1:0] ex_rd;
  logic             mem_isValid, mem_regWrite;
  logic [REG_W-1:0] mem_rd;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_target;
  logic             stall, bubble, flush, pc_sel;
  logic [XLEN-1:0]  pc_target;
  logic [1:0]       forwA, forwB;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_owed  = 0;
  int m_sc    = 0;
  int m_fc    = 0;

  hazard_ctrl #(.REG_W(REG_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .isForw_ON(isForw_ON),
    .id_isValid(id_isValid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_isValid(ex_isValid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .mem_isValid(mem_isValid), .mem_regWrite(mem_regWrite),
    .mem_rd(mem_rd), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .stall(stall), .bubble(bubble), .flush(flush), .pc_sel(pc_sel),
    .pc_target(pc_target), .forwA(forwA), .forwB(forwB),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stall cycles a single source demands, straight from the dependence rules.
  function automatic int src_need(input logic use_it, input logic [REG_W-1:0] rs);
    bit ex_hit, mem_hit;
    if (!(id_isValid && use_it) || rs == 0) return 0;
    ex_hit  = ex_isValid && ex_regWrite && ex_rd == rs;
    mem_hit = mem_isValid && mem_regWrite && mem_rd == rs;
    if (isForw_ON) return (ex_hit && ex_memRead) ? 1 : 0;
    if (ex_hit) return 2;
    if (mem_hit) return 1;
    return 0;
  endfunction

  function automatic int src_fwd(input logic use_it, input logic [REG_W-1:0] rs);
    if (!isForw_ON || !(id_isValid && use_it) || rs == 0) return 0;
    if (ex_isValid && ex_regWrite && ex_rd == rs && !ex_memRead) return 1;
    if (mem_isValid && mem_regWrite && mem_rd == rs) return 2;
    return 0;
  endfunction

  function automatic int need_now();
    int a, b;
    a = src_need(id_use_rs1, id_rs1);
    b = src_need(id_use_rs2, id_rs2);
    return (a > b) ? a : b;
  endfunction

  // Model state: cycles of stall still owed after this one, and counters.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owed = 0;
      m_sc   = 0;
      m_fc   = 0;
    end else if (ex_redirect) begin
      m_owed = 0;
      m_fc   = (m_fc < SAT) ? m_fc + 1 : SAT;
    end else if (m_owed > 0) begin
      m_owed = m_owed - 1;
      m_sc   = (m_sc < SAT) ? m_sc + 1 : SAT;
    end else if (need_now() > 0) begin
      m_owed = need_now() - 1;
      m_sc   = (m_sc < SAT) ? m_sc + 1 : SAT;
    end
  end

  always @(negedge clk) begin
    logic e_stall;
    e_stall = !ex_redirect && (m_owed > 0 || need_now() > 0);
    chk("cyc_stall", 32'(stall), 32'(e_stall));
    chk("cyc_bubble", 32'(bubble), 32'(e_stall || ex_redirect));
    chk("cyc_flush", 32'(flush), 32'(ex_redirect));
    chk("cyc_pc_sel", 32'(pc_sel), 32'(ex_redirect));
    chk("cyc_pc_target", pc_target, ex_redirect ? ex_target : 32'h0);
    chk("cyc_forwA", 32'(forwA), e_stall ? 32'h0 : 32'(src_fwd(id_use_rs1, id_rs1)));
    chk("cyc_forwB", 32'(forwB), e_stall ? 32'h0 : 32'(src_fwd(id_use_rs2, id_rs2)));
    chk("cyc_stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("cyc_flush_cnt", 32'(flush_cnt), 32'(m_fc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_isValid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_isValid = 0; ex_regWrite = 0; ex_memRead = 0; ex_rd = 0;
    mem_isValid = 0; mem_regWrite = 0; mem_rd = 0;
    ex_redirect = 0; ex_target = 0;
  endtask

  task automatic ex_prod(input logic [REG_W-1:0] rd, input logic load);
    ex_isValid = 1; ex_regWrite = 1; ex_memRead = load; ex_rd = rd;
  endtask

  task automatic mem_prod(input logic [REG_W-1:0] rd);
    ex_isValid = 0; ex_regWrite = 0; ex_memRead = 0; ex_rd = 0;
    mem_isValid = 1; mem_regWrite = 1; mem_rd = rd;
  endtask

  task automatic id_rs1_use(input logic [REG_W-1:0] r);
    id_isValid = 1; id_use_rs1 = 1; id_rs1 = r;
  endtask

  initial begin
    reset = 0; isForw_ON = 0;
    clr();
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_pc_target", pc_target, 32'h0);
    chk("rst_fwd", 32'({forwA, forwB}), 32'h0);
    chk("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'h0);
    tick(); tick();
    reset = 1;

    // EX ALU producer forwarded
    tick(); isForw_ON = 1; clr(); ex_prod(5, 0); id_rs1_use(5); #1;
    chk("fwd_ex_forwA", 32'(forwA), 32'h1);
    chk("fwd_ex_stall", 32'(stall), 32'h0);

    // Load-use: one bubble, then MEM/WB forward
    tick(); clr(); ex_prod(6, 1); id_isValid = 1; id_use_rs2 = 1; id_rs2 = 6; #1;
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_bubble", 32'(bubble), 32'h1);
    tick(); mem_prod(6); #1;
    chk("lu_after_stall", 32'(stall), 32'h0);
    chk("lu_forwB", 32'(forwB), 32'h2);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'h1);

    // Forwarding off: EX dependence stalls exactly two cycles
    tick(); isForw_ON = 0; clr(); ex_prod(7, 0); id_rs1_use(7); #1;
    chk("nf_c1_stall", 32'(stall), 32'h1);
    chk("nf_c1_forwA", 32'(forwA), 32'h0);
    tick(); mem_prod(7); #1;
    chk("nf_c2_stall", 32'(stall), 32'h1);
    tick(); mem_isValid = 0; mem_regWrite = 0; #1;
    chk("nf_c3_stall", 32'(stall), 32'h0);
    chk("nf_stall_cnt", 32'(stall_cnt), 32'h3);

    // Forwarding off: MEM dependence stalls one cycle
    tick(); clr(); mem_prod(9); id_rs1_use(9); #1;
    chk("nf_mem_stall", 32'(stall), 32'h1);
    tick(); clr(); id_rs1_use(9); #1;
    chk("nf_mem_done", 32'(stall), 32'h0);

    // x0 never matches; unused source never stalls
    tick(); isForw_ON = 1; clr(); ex_prod(0, 0); id_rs1_use(0); #1;
    chk("x0_stall", 32'(stall), 32'h0);
    chk("x0_forwA", 32'(forwA), 32'h0);
    tick(); isForw_ON = 0; clr(); ex_prod(5, 0); id_isValid = 1; id_rs1 = 5; #1;
    chk("nouse_stall", 32'(stall), 32'h0);

    // Redirect during STALL abandons the stall
    tick(); clr(); ex_prod(7, 0); id_rs1_use(7); #1;
    chk("rd_c1_stall", 32'(stall), 32'h1);
    tick(); mem_prod(7); ex_redirect = 1; ex_target = 32'h40; #1;
    chk("rd_flush", 32'(flush), 32'h1);
    chk("rd_pc_sel", 32'(pc_sel), 32'h1);
    chk("rd_pc_target", pc_target, 32'h40);
    chk("rd_stall", 32'(stall), 32'h0);
    tick(); clr(); #1;
    chk("rd_after_stall", 32'(stall), 32'h0);
    chk("rd_flush_cnt", 32'(flush_cnt), 32'h1);

    // Simultaneous hazard and redirect in RUN
    tick(); clr(); ex_prod(7, 0); id_rs1_use(7); ex_redirect = 1; ex_target = 32'h80; #1;
    chk("sim_stall", 32'(stall), 32'h0);
    chk("sim_flush", 32'(flush), 32'h1);
    tick(); clr(); #1;
    chk("sim_stall_cnt", 32'(stall_cnt), 32'h5);
    chk("sim_flush_cnt", 32'(flush_cnt), 32'h2);

    // Async reset mid-stall
    tick(); clr(); ex_prod(7, 0); id_rs1_use(7);
    tick(); mem_prod(7); #2;
    reset = 0; #1;
    chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("arst_flush_cnt", 32'(flush_cnt), 32'h0);
    clr(); #1;
    chk("arst_state_run", 32'(stall), 32'h0);
    tick(); reset = 1; #1;
    chk("arst_no_carry", 32'(stall), 32'h0);

    // Toggle forwarding during STALL
    tick(); isForw_ON = 0; clr(); ex_prod(7, 0); id_rs1_use(7);
    tick(); isForw_ON = 1; mem_prod(7); #1;
    chk("tog_still_stall", 32'(stall), 32'h1);
    tick(); clr(); #1;
    chk("tog_done", 32'(stall), 32'h0);

    // Saturation of both counters
    tick(); clr(); ex_prod(6, 1); id_isValid = 1; id_use_rs2 = 1; id_rs2 = 6;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hF);
    clr(); ex_redirect = 1; ex_target = 32'h100;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_flush_cnt", 32'(flush_cnt), 32'hF);
    chk("sat_stall_hold", 32'(stall_cnt), 32'hF);
    clr();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). It sits beside the ID stage and decides, each cycle, whether to hold IF/ID, inject a bubble into ID/EX, or flush on an EX-resolved redirect. It produces the ID-stage forwarding selects and saturating stall/flush event counters. Behaviour depends on the runtime `isForw_ON` switch.

## Interface
Parameters:
- `REG_W`, 5, register index width
- `XLEN`, 32, PC/target width
- `CNT_W`, 32, event counter width

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; block in reset while 0
- `isForw_ON`  in  1  1 = forwarding enabled
- `id_isValid`, `id_use_rs1`, `id_use_rs2`  in  1  ID valid / source actually read
- `id_rs1`, `id_rs2`  in  REG_W  ID source registers
- `ex_isValid`, `ex_regWrite`, `ex_memRead`  in  1  EX producer info
- `ex_rd`  in  REG_W
- `mem_isValid`, `mem_regWrite`  in  1  MEM producer info
- `mem_rd`  in  REG_W
- `ex_redirect`  in  1  taken branch or jump resolved in EX
- `ex_target`  in  XLEN  redirect PC
- `stall`  out  1  hold PC and IF/ID
- `bubble`  out  1  load NOP (isValid=0) into ID/EX
- `flush`  out  1  invalidate IF/ID
- `pc_sel`  out  1  1 = PC takes `pc_target`
- `pc_target`  out  XLEN
- `forwA`, `forwB`  out  2  00 regfile, 01 EX/MEM ALU result, 10 MEM/WB data, 11 unused
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters

## Operation
- A producer matches a source when the producer is valid, has regWrite=1, and rd equals the source. The source must also be used, and rd must be nonzero. x0 never matches.
- The register file is write-first, so a WB producer never needs forwarding or a stall.
- Required stall count N, computed per source, maximum taken across both sources:
  - `isForw_ON`=1: EX match with memRead=1 gives N=1; everything else gives N=0.
  - `isForw_ON`=0: EX match gives N=2; MEM match gives N=1.
- Forward selects apply only when `isForw_ON`=1 and no stall is starting:
  - EX match (non-load) gives 01.
  - Else MEM match gives 10.
  - Else 00.
  - EX has priority over MEM.
  - When `isForw_ON`=0, or while `stall`=1, selects are 00.
- FSM states: RUN and STALL, with a 2-bit `left` counter.
  - RUN with N>0 and no redirect: stall=1 and bubble=1 this cycle. Next cycle go to STALL with `left`=N-1 if N>1; otherwise stay in RUN.
  - STALL: stall=1 and bubble=1. `left` decrements each cycle; at 1, return to RUN. Hazard detection is not re-evaluated in STALL.
  - Redirect, in any state: flush=1, bubble=1, pc_sel=1, pc_target=ex_target, stall=0. Next state is RUN with `left`=0. Redirect wins over any stall, because the stalled instruction is younger and is discarded.
- Counters:
  - `stall_cnt` increments every cycle `stall`=1.
  - `flush_cnt` increments every cycle `flush`=1.
  - Both saturate at all-ones.

## Timing
- All control outputs are combinational from the inputs and the current state, in the same cycle. The FSM, `left`, and the counters are registered.
- Reset (`reset`=0, async): state=RUN, `left`=0, both counters 0. Combinational outputs follow the inputs: with all inputs at 0, every output is 0.
- Reset deasserted mid-stall: the stall is abandoned and no stall cycles are carried over.
- Load-use with forwarding on: exactly 1 bubble. The consumer then sees forwX=10 in the following cycle.
- Forwarding off, EX dependence: 2 consecutive stall cycles. MEM dependence: 1 stall cycle.
- Simultaneous redirect and hazard: redirect only. `stall_cnt` is unchanged and `flush_cnt` increments by 1.
- `isForw_ON` is sampled every cycle. Toggling it during STALL does not change the remaining `left`.

## Structure
- In `struct_pkg`:
  - `hz_state_e` (RUN, STALL).
  - `fwd_sel_e` (FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10).
  - Constant `LOAD_USE_STALLS`=1.
  - Constants `NOFWD_EX_STALLS`=2 and `NOFWD_MEM_STALLS`=1.
- One sub-module, `hz_src_check`, instantiated twice (rs1, rs2). It is combinational: it takes one source plus the EX/MEM producer info and returns the match flags, that source's N, and its fwd select.
- Counters and FSM live in `hazard_ctrl`.

## Test plan
- Forwarding on: EX `add x5` (regWrite=1), ID `sub` rs1=x5 → forwA=01, stall=0.
- Forwarding on: EX `lw x6`, ID rs2=x6 → stall=1 and bubble=1 for 1 cycle; next cycle (producer in MEM) forwB=10; `stall_cnt`=1.
- Forwarding off: EX writes x7, ID rs1=x7 → stall=1 for exactly 2 cycles, then 0; forwA=00 throughout.
- ex_rd=x0 with regWrite=1 and ID rs1=x0 → no stall, forwA=00. A source matching with `id_use_rs1`=0 → no stall.
- Forwarding off, stall in progress (`left`=1), ex_redirect=1 with ex_target=0x0000_0040 → flush=1, pc_sel=1, pc_target=0x40, stall=0; next cycle RUN; `flush_cnt`=1.
- Assert `reset`=0 asynchronously during STALL → state returns to RUN and counters reset to 0 without waiting for a clock edge. Force `stall_cnt` to all-ones, then stall → the counter holds at all-ones.
